// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 codes, FSM states,
// byte-enable patterns and small helpers for access sizing and alignment.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unlisted funct3 codes fall through to a full-word access.
    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input access_size_e size,
                                               input logic [1:0]   offset);
        case (size)
            SZ_BYTE: return BE_BYTE << offset;
            SZ_HALF: return BE_HALF << {offset[1], 1'b0};
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input access_size_e size,
                                        input logic [1:0]   offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select and sign/zero extension from the raw bus word,
// the byte offset of the access and its funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    result = {{16{half_lane[15]}}, half_lane};
            F3_BU:   result = {24'h0, byte_lane};
            F3_HU:   result = {16'h0, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one data-bus transaction per load/store and
// stalls the pipeline until it completes. Optional macro LSU_MISALIGN_TRAP_EN adds misalign_m_o.
//
// state | meaning
// IDLE  | no transaction; a new load/store registers the bus fields and raises req
// REQ   | request outstanding, bus outputs held until ack
// DONE  | one unstalled cycle while the M/WB register captures read_data_m_o
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_read_m_i,
    input  logic                     mem_write_m_i,
    input  logic [2:0]               funct3_m_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_result_m_i,
    input  logic [DATA_WIDTH-1:0]    write_data_m_i,
    input  logic                     flush_m_i,
    output logic [DATA_WIDTH-1:0]    read_data_m_o,
    output logic                     stall_m_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]               dmem_be_o,
    output logic [DATA_WIDTH-1:0]    dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata_i,
    input  logic                     dmem_ack_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                     misalign_m_o
`endif
);

    lsu_state_e   state;
    lsu_state_e   state_next;
    logic         op;
    access_size_e size;
    logic [3:0]   be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic         misalign_now;
    logic [1:0]   offset_q;
    logic [2:0]   funct3_q;
    logic [31:0]  load_data;

    assign op      = (mem_read_m_i | mem_write_m_i) & ~flush_m_i;
    assign size    = access_size(funct3_m_i);
    assign be_next = byte_enable(size, alu_result_m_i[1:0]);

    always_comb begin
        wdata_next = write_data_m_i;
        case (size)
            SZ_BYTE: wdata_next = {4{write_data_m_i[7:0]}};
            SZ_HALF: wdata_next = {2{write_data_m_i[15:0]}};
            default: wdata_next = write_data_m_i;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misalign_now = misaligned(size, alu_result_m_i[1:0]);
    assign misalign_m_o = (state == DONE) & misalign_q;
`else
    // Misaligned low bits are simply dropped by the aligned address and lane select.
    assign misalign_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (op) begin
                    state_next = misalign_now ? DONE : REQ;
                end
            end
            REQ: begin
                if (dmem_ack_i) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_m_o = ((state == IDLE) & op) | (state == REQ);

    lsu_load_ext u_load_ext (
        .rdata  (dmem_rdata_i),
        .offset (offset_q),
        .funct3 (funct3_q),
        .result (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= '0;
            dmem_be_o     <= '0;
            dmem_wdata_o  <= '0;
            read_data_m_o <= '0;
            offset_q      <= '0;
            funct3_q      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign_q <= misalign_now;
`endif
                        if (misalign_now) begin
                            read_data_m_o <= '0;
                        end else begin
                            // A read+write collision resolves as a store.
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_m_i;
                            dmem_addr_o  <= {alu_result_m_i[ADDRESS_WIDTH-1:2], 2'b00};
                            dmem_be_o    <= be_next;
                            dmem_wdata_o <= wdata_next;
                            offset_q     <= alu_result_m_i[1:0];
                            funct3_q     <= funct3_m_i;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        if (!dmem_we_o) begin
                            read_data_m_o <= load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
